fetch_npc_unit: RTL and testbench

Fetch-stage program counter, next-PC selection and F/D pipeline register for the five-stage MIPS core. It drives the instruction-memory address, latches the fetched word into D, and resolves branches and jumps in D. Its inputs are the D-stage comparator flags (equal, rs ≥ 0) and the forwarded rs value. Branches use one delay slot, and no instruction is ever flushed.

---
 rtl/fetch_npc_unit.sv | 89 ++++++++
 tb/tb_fetch_npc_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_npc_unit.sv
// Fetch-stage PC, next-PC selection and F/D pipeline register.
// Branches and jumps resolve in D with one delay slot; nothing is ever flushed.
module fetch_npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic [2:0]  npc_op_d,
    input  logic        equ_d,
    input  logic        gez_d,
    input  logic [31:0] rs_fwd_d,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        taken_d
);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BGEZ = 3'b011;
    localparam logic [2:0] OP_BLTZ = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;

    logic [31:0] fpc_q,   fpc_d;
    logic [31:0] dinstr_q, dinstr_d;
    logic [31:0] dpc_q,   dpc_d;
    logic [31:0] br_tgt, j_tgt, target, npc;

    // Redirect is recomputed every cycle from the held D state, so a stalled
    // jr picks up whatever rs value is forwarded in its first free cycle.
    always_comb begin
        taken_d = 1'b0;
        target  = br_tgt;
        unique case (npc_op_d)
            OP_BEQ:  taken_d = equ_d;
            OP_BNE:  taken_d = ~equ_d;
            OP_BGEZ: taken_d = gez_d;
            OP_BLTZ: taken_d = ~gez_d;
            OP_J: begin
                taken_d = 1'b1;
                target  = j_tgt;
            end
            OP_JR: begin
                taken_d = 1'b1;
                target  = rs_fwd_d;
            end
            OP_SEQ:  taken_d = 1'b0;
            default: taken_d = 1'b0;
        endcase
    end

    assign br_tgt = dpc_q + 32'd4 + {{14{dinstr_q[15]}}, dinstr_q[15:0], 2'b00};
    assign j_tgt  = {dpc_q[31:28], dinstr_q[25:0], 2'b00};
    assign npc    = taken_d ? target : fpc_q + 32'd4;

    always_comb begin
        fpc_d    = fpc_q;
        dinstr_d = dinstr_q;
        dpc_d    = dpc_q;
        if (!stall) begin
            fpc_d    = npc;
            dinstr_d = instr_f;
            dpc_d    = fpc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q    <= RESET_PC;
            dinstr_q <= 32'd0;
            dpc_q    <= 32'd0;
        end else begin
            fpc_q    <= fpc_d;
            dinstr_q <= dinstr_d;
            dpc_q    <= dpc_d;
        end
    end

    assign pc_f    = fpc_q;
    assign instr_d = dinstr_q;
    assign pc_d    = dpc_q;
    assign pc8_d   = dpc_q + 32'd8;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Scoreboarded bench for fetch_npc_unit: directed test-plan scenarios followed
// by randomized traffic, all checked against a cycle-level reference model.
module tb_fetch_npc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instr_f;
    logic [2:0]  npc_op_d;
    logic        equ_d;
    logic        gez_d;
    logic [31:0] rs_fwd_d;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        taken_d;

    fetch_npc_unit #(.RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .instr_f  (instr_f),
        .npc_op_d (npc_op_d),
        .equ_d    (equ_d),
        .gez_d    (gez_d),
        .rs_fwd_d (rs_fwd_d),
        .pc_f     (pc_f),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .pc8_d    (pc8_d),
        .taken_d  (taken_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc8;
        logic        taken;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: what the F/D boundary should hold this cycle.
    bit          m_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_pcd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input bit eq, input bit gz);
        case (op)
            3'd1:    return eq;
            3'd2:    return !eq;
            3'd3:    return gz;
            3'd4:    return !gz;
            3'd5:    return 1'b1;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] ins,
                                               input logic [31:0] pcd, input logic [31:0] rs);
        int          off;
        logic [31:0] t;
        if (op == 3'd6) return rs;
        if (op == 3'd5) return (pcd & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        off = int'($signed(ins[15:0])) * 4;
        t   = pcd + 32'd4 + 32'(off);
        return t;
    endfunction

    // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
    task automatic step(input bit rst, input bit stl, input logic [31:0] ifw,
                        input logic [2:0] op, input bit eq, input bit gz, input logic [31:0] rs);
        exp_t        e;
        bit          n_known;
        logic [31:0] n_pc, n_instr, n_pcd;
        reset = rst; stall = stl; instr_f = ifw;
        npc_op_d = op; equ_d = eq; gez_d = gz; rs_fwd_d = rs;
        e.chk   = m_known;
        e.pc    = m_pc;
        e.instr = m_instr;
        e.pcd   = m_pcd;
        e.pc8   = m_pcd + 32'd8;
        e.taken = ref_taken(op, eq, gz);
        sbq.push_back(e);
        n_known = m_known; n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd;
        if (rst) begin
            n_known = 1'b1; n_pc = RST_PC; n_instr = 32'd0; n_pcd = 32'd0;
        end else if (!stl) begin
            n_pc    = e.taken ? ref_target(op, m_instr, m_pcd, rs) : m_pc + 32'd4;
            n_instr = ifw;
            n_pcd   = m_pc;
        end
        @(posedge clk);
        m_known = n_known; m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd;
        #1;
    endtask

    task automatic seq_step();
        step(1'b0, 1'b0, $urandom, 3'd0, 1'($urandom), 1'($urandom), $urandom);
    endtask

    task automatic do_reset();
        step(1'b1, 1'($urandom), $urandom, 3'd0, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'($urandom), $urandom, 3'd0, 1'b0, 1'b0, $urandom);
    endtask

    // Reset, fetch `pre` fillers, fetch `word`, then resolve it in D with `op`.
    task automatic scen(input string name, input int pre, input logic [31:0] word,
                        input logic [2:0] op, input bit eq, input bit gz,
                        input logic [31:0] rs, input logic [31:0] exp_pc);
        do_reset();
        repeat (pre) seq_step();
        step(1'b0, 1'b0, word, 3'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, $urandom, op, eq, gz, rs);
        check(name, pc_f, exp_pc);
        seq_step();
    endtask

    // Monitor: every cycle the block presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    check("pc_f",    pc_f,           e.pc);
                    check("instr_d", instr_d,        e.instr);
                    check("pc_d",    pc_d,           e.pcd);
                    check("pc8_d",   pc8_d,          e.pc8);
                    check("taken_d", {31'd0, taken_d}, {31'd0, e.taken});
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; instr_f = 32'd0; npc_op_d = 3'd0;
        equ_d = 1'b0; gez_d = 1'b0; rs_fwd_d = 32'd0;
        @(posedge clk); #1;

        do_reset();
        check("rst_pc_f", pc_f, 32'h0000_3000);
        check("rst_pc8_d", pc8_d, 32'h0000_0008);
        seq_step();
        check("seq_pc_f_1", pc_f, 32'h0000_3004);
        seq_step();
        check("seq_pc_f_2", pc_f, 32'h0000_3008);
        check("seq_pc_d_2", pc_d, 32'h0000_3004);

        scen("beq_taken",    0, 32'h1000_0003, 3'd1, 1'b1, 1'b0, 32'd0, 32'h0000_3010);
        scen("beq_nottaken", 0, 32'h1000_0003, 3'd1, 1'b0, 1'b0, 32'd0, 32'h0000_3008);
        scen("bne_taken",    0, 32'h1400_0003, 3'd2, 1'b0, 1'b0, 32'd0, 32'h0000_3010);
        scen("bgez_taken",   2, 32'h0401_FFFF, 3'd3, 1'b0, 1'b1, 32'd0, 32'h0000_3008);
        scen("bgez_not",     2, 32'h0401_FFFF, 3'd3, 1'b0, 1'b0, 32'd0, 32'h0000_3010);
        scen("bltz_gez1",    2, 32'h0400_FFFF, 3'd4, 1'b0, 1'b1, 32'd0, 32'h0000_3010);
        scen("bltz_gez0",    2, 32'h0400_FFFF, 3'd4, 1'b0, 1'b0, 32'd0, 32'h0000_3008);
        scen("jal",          2, 32'h0C00_0C00, 3'd5, 1'b0, 1'b0, 32'd0, 32'h0000_3000);
        scen("op7_seq",      0, 32'h1000_0003, 3'd7, 1'b1, 1'b1, 32'd0, 32'h0000_3008);

        // jr held in D by a two-cycle stall; only the unstalled rs value counts.
        do_reset();
        step(1'b0, 1'b0, 32'h0320_0008, 3'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, $urandom, 3'd6, 1'b0, 1'b0, 32'h1111_1110);
        step(1'b0, 1'b1, $urandom, 3'd6, 1'b0, 1'b0, 32'h1111_1110);
        check("jr_stall_hold", pc_f, 32'h0000_3004);
        step(1'b0, 1'b0, $urandom, 3'd6, 1'b0, 1'b0, 32'h0000_3040);
        check("jr_stall_tgt", pc_f, 32'h0000_3040);

        // Wrap-around past the top of the address space.
        do_reset();
        step(1'b0, 1'b0, 32'h0320_0008, 3'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, $urandom, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFC);
        check("wrap_jr", pc_f, 32'hFFFF_FFFC);
        seq_step();
        check("wrap_seq", pc_f, 32'h0000_0000);

        // Reset beats stall, including mid-branch.
        step(1'b0, 1'b0, 32'h1000_0003, 3'd0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, $urandom, 3'd1, 1'b1, 1'b0, 32'd0);
        check("rst_dominance", pc_f, 32'h0000_3000);
        check("rst_dom_instr", instr_d, 32'h0000_0000);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom,
                 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom);
        end

        for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
